fb_stream_reader: RTL and testbench
===================================

Name: fb_stream_reader

Overview:
- Wishbone classic-cycle master on sys_clk; reads the framebuffer from SDRAM linearly, one 32-bit word per pixel.
- Pushes pixels, with a start-of-frame tag, through an internal FIFO to a valid/ready stream.
- Sits between the SDRAM Wishbone slave and the pixel-domain clock-crossing FIFO that feeds vga.

Parameters:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0).
- DEPTH, 8, internal FIFO entries; power of 2, 4 or more.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = fetch frames continuously.
- wb_adr  out  32  byte address.
- wb_cyc  out  1  cycle.
- wb_stb  out  1  strobe.
- wb_we  out  1  tied 0.
- wb_sel  out  4  tied 4'hF.
- wb_cti  out  3  3'b000 (classic).
- wb_bte  out  2  2'b00.
- wb_dat_i  in  32  read data; pixel = bits [23:0] (R,G,B).
- wb_ack  in  1  normal termination.
- wb_err  in  1  error termination.
- wb_rty  in  1  retry termination.
- pix_data  out  24  RGB pixel.
- pix_sof  out  1  1 on pixel index 0 of a frame.
- pix_valid  out  1  FIFO not empty.
- pix_ready  in  1  downstream accepts; transfer = pix_valid and pix_ready.
- err_cnt  out  16  saturating count of wb_err terminations.

Behaviour:
- Reset (sys_rst_n=0, async): FIFO empty, pixel index 0, running=0.
  - Reset output values: wb_cyc=wb_stb=0, wb_adr=BASE_ADDR, pix_valid=0, pix_data=0, pix_sof=0, err_cnt=0.
- Pixel index runs 0..HDISP*VDISP-1; counter width is $clog2(HDISP*VDISP).
  - wb_adr = BASE_ADDR + 4*index, registered; updates the cycle after a termination.
- State machine has two states.
  - IDLE to RUN: enable=1.
  - RUN to IDLE: enable=0 and (wb_stb=0 or a termination this cycle).
  - On entering IDLE: FIFO flushed, index cleared to 0.
- wb_cyc = wb_stb = RUN and FIFO not full (count < DEPTH). Combinational from registered state only; no combinational path from wb_ack.
  - Once asserted, stb stays high until terminated, even if enable falls.
- wb_ack: push {sof=(index==0), wb_dat_i[23:0]}, then index += 1.
  - At index HDISP*VDISP-1 the index wraps to 0.
  - Back-to-back acks give 1 pixel per cycle.
- wb_err: push {sof, 24'h000000}, advance index as for ack, err_cnt += 1 (saturates at 16'hFFFF).
- wb_rty: no push, index unchanged; same address re-presented next cycle.
- Simultaneous terminations: priority ack > err > rty.
- FIFO behaviour:
  - Registered-output synchronous FIFO; first pixel appears on pix_data 1 cycle after its ack.
  - pix_data/pix_sof hold stable while pix_valid=1 and pix_ready=0.
  - Simultaneous push and pop at full or empty is legal; count unchanged.
- Full: stb drops the cycle count reaches DEPTH and resumes the cycle after a pop.
- Empty: pix_valid=0; pix_data holds its last value.
- enable toggled mid-frame: next RUN restarts at index 0 with sof=1.

Optional Feature:
- Macro: FB_SWAP_EN.
- Defined:
  - Extra input fb_sel (1 bit).
  - Base address = BASE_ADDR + fb_sel_q*(4*HDISP*VDISP).
  - fb_sel_q samples fb_sel only when the index wraps to 0 or on the IDLE to RUN transition, so a frame never mixes buffers.
- Undefined: port absent; base address fixed at BASE_ADDR.

Test Plan:
- HDISP=4, VDISP=2, DEPTH=4, pix_ready=1, ack every cycle:
  - adr sequence 0x00,0x04,...,0x1C, then 0x00.
  - pix_sof=1 exactly on pixels 0 and 8.
  - data = wb_dat_i[23:0], 1-cycle latency.
- pix_ready=0 for 10 cycles: exactly 4 pixels buffered, stb=0 from the cycle count=4.
  - On pix_ready=1: no pixel lost or duplicated; stb reasserts the cycle after the first pop.
- wb_rty on address 0x08 for 3 cycles, then ack: adr stays 0x08; the pixel sequence has no gap or duplicate.
- wb_err on index 5: pixel 5 = 24'h000000, err_cnt=1, next adr=0x18.
- enable=0 while stb pending at index 3: stb held until ack; then IDLE, FIFO empty, pix_valid=0.
  - Re-enable: adr=0x00, first pixel sof=1.
- sys_rst_n pulsed low mid-transfer: wb_cyc=wb_stb=0 and pix_valid=0 immediately (async), err_cnt=0, adr=BASE_ADDR.
  - With FB_SWAP_EN: fb_sel changed mid-frame takes effect only at the next 0x00-relative wrap (base 0x20 for 4x2).

Source files
------------

// File: rtl/fb_stream_reader.sv
// fb_stream_reader: Wishbone classic-cycle master that reads the framebuffer
// linearly (one 32-bit word per pixel) and streams pixels, tagged with a
// start-of-frame flag, through a small registered-output FIFO to a
// valid/ready interface.
//
// Optional feature: define FB_SWAP_EN to add the fb_sel input and
// double-buffer support. The selected buffer is sampled only at frame
// boundaries, so a single frame never mixes buffers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | not fetching; FIFO and pixel index held cleared
// ST_RUN  | fetching; strobe asserted whenever the FIFO has room
module fb_stream_reader #(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
`ifdef FB_SWAP_EN
  input  logic        fb_sel,
`endif
  output logic [31:0] wb_adr,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_rty,
  output logic [23:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] err_cnt
);

  localparam int unsigned NPIX  = HDISP * VDISP;
  localparam int unsigned IDX_W = $clog2(NPIX);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [24:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [24:0]      out_q, out_d;
  logic             out_en;
  logic [31:0]      adr_q, adr_d, base_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic        stb;
  logic        term;
  logic        push;
  logic        pop;
  logic        last;
  logic        flush;
  logic [24:0] push_data;
  logic        unused_dat;

  // Upper byte of each framebuffer word carries no pixel information.
  assign unused_dat = ^wb_dat_i[31:24];

  // Strobe depends on registered state only, never on the termination inputs.
  assign stb       = (state_q == ST_RUN) && (cnt_q != FULL_CNT);
  assign term      = stb && (wb_ack || wb_err || wb_rty);
  assign push      = stb && (wb_ack || wb_err);
  assign push_data = {(idx_q == '0), (wb_ack ? wb_dat_i[23:0] : 24'h000000)};
  assign pop       = (cnt_q != '0) && pix_ready;
  assign last      = (idx_q == LAST_IDX);

`ifdef FB_SWAP_EN
  localparam logic [31:0] FB_STRIDE = 32'(4 * NPIX);

  logic fb_sel_q, fb_sel_d;
  logic start;
  logic wrap;

  assign start = (state_q == ST_IDLE) && (state_d == ST_RUN);
  assign wrap  = push && last;

  // Buffer select changes only at a frame boundary or a fresh start.
  always_comb begin
    fb_sel_d = fb_sel_q;
    if (wrap || start) fb_sel_d = fb_sel;
    base_d = fb_sel_d ? (BASE_ADDR + FB_STRIDE) : BASE_ADDR;
  end

  // Buffer select register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) fb_sel_q <= 1'b0;
    else            fb_sel_q <= fb_sel_d;
  end
`else
  assign base_d = BASE_ADDR;
`endif

  // Next-state logic: leave RUN only once no strobe is left outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (!enable && (!stb || term)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign flush = (state_q == ST_RUN) && (state_d == ST_IDLE);

  // Pixel index, FIFO pointers/count, output register and address next values.
  always_comb begin
    idx_d    = idx_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_next  = rd_ptr_q + PTR_W'(pop);
    rd_ptr_d = rd_next;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    out_d    = mem_q[rd_next];
    out_en   = 1'b0;
    if (push) idx_d = last ? '0 : idx_q + 1'b1;
    // A push into an otherwise-empty FIFO goes straight to the output register.
    if (push && (cnt_q == CNT_W'(pop))) out_d = push_data;
    if (cnt_d != '0) out_en = 1'b1;
    if (flush) begin
      idx_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      out_en   = 1'b0;
    end
    adr_d = base_d + {{(30 - IDX_W){1'b0}}, idx_d, 2'b00};
  end

  // Error counter saturates instead of wrapping.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (stb && !wb_ack && wb_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Control and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      adr_q     <= BASE_ADDR;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      if (out_en) out_q <= out_d;
      adr_q     <= adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign wb_adr    = adr_q;
  assign wb_cyc    = stb;
  assign wb_stb    = stb;
  assign wb_we     = 1'b0;
  assign wb_sel    = 4'hF;
  assign wb_cti    = 3'b000;
  assign wb_bte    = 2'b00;
  assign pix_valid = (cnt_q != '0);
  assign pix_data  = out_q[23:0];
  assign pix_sof   = out_q[24];
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fb_stream_reader.sv
// Testbench for fb_stream_reader with a 4x2 frame and a 4-entry FIFO.
module tb_fb_stream_reader;

  localparam int NPIX  = 8;
  localparam int DEPTH = 4;
  localparam int R_NONE = 0, R_ACK = 1, R_ERR = 2, R_RTY = 3, R_ALL = 4, R_ERRRTY = 5;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        enable;
  logic [31:0] wb_adr;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] wb_dat_i;
  logic        wb_ack, wb_err, wb_rty;
  logic [23:0] pix_data;
  logic        pix_sof, pix_valid, pix_ready;
  logic [15:0] err_cnt;
`ifdef FB_SWAP_EN
  logic        fb_sel;
  logic        fb_q;
`endif

  int tests = 0;
  int fails = 0;

  logic [24:0] exp_q [$];
  int          exp_idx;
  logic        exp_run;
  logic [15:0] exp_err;

  typedef struct {
    logic        en;
    logic        rdy;
    int          resp;
    logic [31:0] exp_adr;
    logic        exp_stb;
  } vec_t;
  vec_t vecs [12];

  fb_stream_reader #(
    .HDISP(4), .VDISP(2), .BASE_ADDR(32'h0000_0000), .DEPTH(DEPTH)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
`ifdef FB_SWAP_EN
    .fb_sel(fb_sel),
`endif
    .wb_adr(wb_adr), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_base();
`ifdef FB_SWAP_EN
    return fb_q ? 32'h20 : 32'h0;
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic exp_stb_f();
    return exp_run && (exp_q.size() < DEPTH);
  endfunction

  // One bus cycle: called at a negedge, compares outputs with the model,
  // drives the slave response, and advances the model across the posedge.
  task automatic step(input int kind, input logic rdy);
    logic        stb_m, term, is_ack, is_err, wrapped;
    logic [31:0] d;
    logic [24:0] e;
    pix_ready = rdy;
    stb_m = exp_stb_f();
    chk("stb", 32'(wb_stb), 32'(stb_m));
    chk("cyc", 32'(wb_cyc), 32'(stb_m));
    chk("adr", wb_adr, exp_base() + 32'(4 * exp_idx));
    chk("valid", 32'(pix_valid), 32'(exp_q.size() != 0));
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
    if (pix_valid && rdy) begin
      if (exp_q.size() == 0) chk("pixel_extra", 32'(pix_data), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("pixel", 32'({pix_sof, pix_data}), 32'(e));
      end
    end
    is_ack = (kind == R_ACK) || (kind == R_ALL);
    is_err = (kind == R_ERR) || (kind == R_ERRRTY);
    d = $urandom();
    wb_dat_i = d;
    wb_ack = wb_stb && is_ack;
    wb_err = wb_stb && (is_err || kind == R_ALL);
    wb_rty = wb_stb && (kind == R_RTY || kind == R_ALL || kind == R_ERRRTY);
    @(posedge sys_clk);
    term = stb_m && (kind != R_NONE);
    wrapped = 1'b0;
    if (stb_m && (is_ack || is_err)) begin
      exp_q.push_back({(exp_idx == 0), (is_ack ? d[23:0] : 24'h000000)});
      if (!is_ack && exp_err != 16'hFFFF) exp_err++;
      if (exp_idx == NPIX - 1) begin
        exp_idx = 0;
        wrapped = 1'b1;
      end else exp_idx++;
    end
`ifdef FB_SWAP_EN
    if (wrapped || (!exp_run && enable)) fb_q = fb_sel;
`endif
    if (!exp_run) begin
      if (enable) exp_run = 1'b1;
    end else if (!enable && (!stb_m || term)) begin
      exp_run = 1'b0;
      exp_q.delete();
      exp_idx = 0;
    end
    @(negedge sys_clk);
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_rty = 1'b0;
  endtask

  // Ack until the model says a strobe is pending at the given index.
  task automatic run_to(input int idx);
    int n = 0;
    while (!(exp_stb_f() && exp_idx == idx) && n < 64) begin
      step(R_ACK, 1'b1);
      n++;
    end
    chk("run_to_bound", 32'(n < 64), 32'd1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_idx = 0;
    exp_run = 1'b0;
    exp_err = 16'd0;
`ifdef FB_SWAP_EN
    fb_q = 1'b0;
`endif
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      vecs[i].en      = 1'b1;
      vecs[i].rdy     = 1'b1;
      vecs[i].resp    = R_ACK;
      vecs[i].exp_stb = (i != 0);
      vecs[i].exp_adr = (i == 0) ? 32'h0 : 32'(((i - 1) % 8) * 4);
    end

    sys_rst_n = 1'b0;
    enable    = 1'b0;
    pix_ready = 1'b0;
    wb_dat_i  = 32'h0;
    wb_ack    = 1'b0;
    wb_err    = 1'b0;
    wb_rty    = 1'b0;
`ifdef FB_SWAP_EN
    fb_sel    = 1'b0;
`endif
    model_reset();

    repeat (2) @(negedge sys_clk);
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_adr", wb_adr, 32'h0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_sof", 32'(pix_sof), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("tied_bus", {24'h0, wb_we, wb_sel, wb_cti}, 32'h0000_0078);
    chk("tied_bte", 32'(wb_bte), 32'd0);
    sys_rst_n = 1'b1;

    // Linear fetch over more than one frame, 1 pixel per cycle.
    for (int i = 0; i < 12; i++) begin
      enable = vecs[i].en;
      chk("tbl_adr", wb_adr, vecs[i].exp_adr);
      chk("tbl_stb", 32'(wb_stb), 32'(vecs[i].exp_stb));
      step(vecs[i].resp, vecs[i].rdy);
    end

    // Backpressure: FIFO fills to DEPTH, strobe stops, then resumes after a pop.
    repeat (10) step(R_ACK, 1'b0);
    chk("full_stb", 32'(wb_stb), 32'd0);
    chk("full_valid", 32'(pix_valid), 32'd1);
    step(R_ACK, 1'b1);
    chk("stb_resume", 32'(wb_stb), 32'd1);
    repeat (6) step(R_ACK, 1'b1);

    // Retry holds the address and pushes nothing.
    run_to(2);
    repeat (3) begin
      chk("rty_adr", wb_adr, exp_base() + 32'h08);
      step(R_RTY, 1'b1);
    end
    chk("rty_adr", wb_adr, exp_base() + 32'h08);
    step(R_ACK, 1'b1);

    // Error termination at index 5 pushes a black pixel and advances.
    run_to(5);
    step(R_ERR, 1'b1);
    chk("err_cnt_1", 32'(err_cnt), 32'd1);
    chk("err_next_adr", wb_adr, exp_base() + 32'h18);

    // Simultaneous terminations: ack over err over rty.
    step(R_ALL, 1'b1);
    chk("prio_ack", 32'(err_cnt), 32'd1);
    step(R_ERRRTY, 1'b1);
    chk("prio_err", 32'(err_cnt), 32'd2);
    repeat (3) step(R_ACK, 1'b1);

    // Disable with a strobe pending: held until acked, then flushed to IDLE.
    run_to(3);
    enable = 1'b0;
    step(R_NONE, 1'b0);
    step(R_NONE, 1'b0);
    chk("stb_hold", 32'(wb_stb), 32'd1);
    step(R_ACK, 1'b0);
    chk("idle_valid", 32'(pix_valid), 32'd0);
    chk("idle_stb", 32'(wb_stb), 32'd0);
    chk("idle_adr", wb_adr, exp_base());
    enable = 1'b1;
    step(R_NONE, 1'b1);
    chk("reen_adr", wb_adr, exp_base());
    step(R_ACK, 1'b1);
    chk("reen_sof", 32'({pix_valid, pix_sof}), 32'd3);
    repeat (5) step(R_ACK, 1'b1);

    // Asynchronous reset between clock edges.
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(wb_cyc), 32'd0);
    chk("arst_stb", 32'(wb_stb), 32'd0);
    chk("arst_valid", 32'(pix_valid), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_adr", wb_adr, 32'h0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (6) step(R_ACK, 1'b1);

`ifdef FB_SWAP_EN
    // Buffer select changes mid-frame; takes effect at the next wrap.
    run_to(3);
    fb_sel = 1'b1;
    run_to(0);
    chk("swap_adr", wb_adr, 32'h20);
    repeat (3) step(R_ACK, 1'b1);
    fb_sel = 1'b0;
    repeat (3) step(R_ACK, 1'b1);
`endif

    repeat (8) step(R_NONE, 1'b1);
    chk("drained", 32'(pix_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
